// File: rtl/count_decoder_if.sv
// rtl/count_decoder_if.sv - event stream bundle between count_decoder and its consumer
interface count_decoder_if #(
  parameter int WIDTH = 1
);
  logic             ev_valid;
  logic             ev_ready;
  logic [1:0]       ev_type;
  logic [WIDTH-1:0] ev_count;

  modport master (
    output ev_valid,
    output ev_type,
    output ev_count,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_type,
    input  ev_count,
    output ev_ready
  );
endinterface

// File: rtl/count_decoder.sv
// rtl/count_decoder.sv - recovers up/down direction from an observed counter and queues step events
module count_decoder #(
  parameter int WIDTH      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   count,
  input  logic               loop,
  output logic               dir,
  output logic               dir_valid,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               loop_mismatch,
  output logic               ev_overflow,
  count_decoder_if.master    ev
);

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [1:0] EV_WRAP_UP   = 2'd0;
  localparam logic [1:0] EV_WRAP_DOWN = 2'd1;
  localparam logic [1:0] EV_DIR_CHG   = 2'd2;
  localparam logic [1:0] EV_STEP_ERR  = 2'd3;

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             dir_q, dir_d;
  logic             dir_valid_q, dir_valid_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             overflow_q, overflow_d;

  logic [1:0]       mem_type_q  [FIFO_DEPTH];
  logic [1:0]       mem_type_d  [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_count_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_count_d [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0] delta;
  logic             step_up;
  logic             step_dn;
  logic             legal;
  logic             active;
  logic             wrap;
  logic             push;
  logic [1:0]       push_type;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  // Up is tested first so that WIDTH=1 (where +1 == -1) always decodes as up.
  assign delta   = count - prev_q;
  assign step_up = (delta == WIDTH'(1));
  assign step_dn = !step_up && (delta == '1);
  assign legal   = step_up || step_dn;
  assign active  = (state_q == ST_ACQ) || (state_q == ST_TRACK);
  assign wrap    = (step_up && (prev_q == '1)) || (step_dn && (prev_q == '0));

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = ev.ev_ready && !fifo_empty;

  always_comb begin
    state_d     = state_q;
    prev_d      = count;
    dir_d       = dir_q;
    dir_valid_d = dir_valid_q;
    wrap_cnt_d  = wrap_cnt_q;
    err_cnt_d   = err_cnt_q;
    mismatch_d  = mismatch_q;
    push        = 1'b0;
    push_type   = EV_STEP_ERR;

    case (state_q)
      ST_SYNC: state_d = ST_ACQ;
      ST_ACQ: begin
        if (legal) begin
          state_d     = ST_TRACK;
          dir_d       = step_up;
          dir_valid_d = 1'b1;
        end
      end
      ST_TRACK: begin
        if (legal) begin
          dir_d = step_up;
        end else begin
          state_d     = ST_ACQ;
          dir_valid_d = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (active && !legal) begin
      push = 1'b1;
      push_type = EV_STEP_ERR;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    // A wrap that also reverses direction reports only the wrap.
    if (active && legal) begin
      if (wrap) begin
        push = 1'b1;
        push_type = step_up ? EV_WRAP_UP : EV_WRAP_DOWN;
        if (wrap_cnt_q != '1) wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
      end else if ((state_q == ST_TRACK) && (step_up != dir_q)) begin
        push = 1'b1;
        push_type = EV_DIR_CHG;
      end
      if (loop != wrap) mismatch_d = 1'b1;
    end
  end

  always_comb begin
    mem_type_d  = mem_type_q;
    mem_count_d = mem_count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;

    // When full, a same-cycle pop frees the slot the push needs.
    if (push) begin
      if (!fifo_full || pop) begin
        mem_type_d[wr_ptr_q[PTR_W-1:0]]  = push_type;
        mem_count_d[wr_ptr_q[PTR_W-1:0]] = count;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      prev_q      <= '0;
      dir_q       <= 1'b0;
      dir_valid_q <= 1'b0;
      wrap_cnt_q  <= '0;
      err_cnt_q   <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_type_q[i]  <= '0;
        mem_count_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      wrap_cnt_q  <= wrap_cnt_d;
      err_cnt_q   <= err_cnt_d;
      mismatch_q  <= mismatch_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_type_q  <= mem_type_d;
      mem_count_q <= mem_count_d;
    end
  end

  assign dir           = dir_q;
  assign dir_valid     = dir_valid_q;
  assign wrap_cnt      = wrap_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign loop_mismatch = mismatch_q;
  assign ev_overflow   = overflow_q;

  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_type  = fifo_empty ? 2'd0 : mem_type_q[rd_ptr_q[PTR_W-1:0]];
  assign ev.ev_count = fifo_empty ? '0 : mem_count_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: tb/tb_count_decoder.sv
// tb/tb_count_decoder.sv - directed vector bench for count_decoder (WIDTH=3, FIFO_DEPTH=4)
module tb_count_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  logic       loop;
  logic       dir;
  logic       dir_valid;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;
  logic       loop_mismatch;
  logic       ev_overflow;

  count_decoder_if #(.WIDTH(3)) evif ();

  count_decoder #(.WIDTH(3), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .loop         (loop),
    .dir          (dir),
    .dir_valid    (dir_valid),
    .wrap_cnt     (wrap_cnt),
    .err_cnt      (err_cnt),
    .loop_mismatch(loop_mismatch),
    .ev_overflow  (ev_overflow),
    .ev           (evif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  cnt;
    logic        lp;
    logic        rdy;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [25:0] pk(input logic d, input logic dv, input logic [7:0] wc,
                                     input logic [7:0] ec, input logic mm, input logic evv,
                                     input logic [1:0] evt, input logic [2:0] evc, input logic ovf);
    return {d, dv, wc, ec, mm, evv, evt, evc, ovf};
  endfunction

  task automatic add(input logic r, input logic [2:0] c, input logic l, input logic rd,
                     input logic d, input logic dv, input logic [7:0] wc, input logic [7:0] ec,
                     input logic mm, input logic evv, input logic [1:0] evt, input logic [2:0] evc,
                     input logic ovf);
    vec_t v;
    v.rst = r; v.cnt = c; v.lp = l; v.rdy = rd;
    v.exp = pk(d, dv, wc, ec, mm, evv, evt, evc, ovf);
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic l, input logic rd);
    rst = r; count = c; loop = l; evif.ev_ready = rd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] actual();
    return {dir, dir_valid, wrap_cnt, err_cnt, loop_mismatch,
            evif.ev_valid, evif.ev_type, evif.ev_count, ev_overflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int c;
  logic [2:0] heads [4];

  initial begin
    // Columns: rst cnt loop rdy | dir dv wrap err mm evv evt evc ovf
    // 1: up count through 7->0 wrap
    add(1,5,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,5,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,6,0,0, 1,1,0,0,0,0,0,0,0);
    add(0,7,0,0, 1,1,0,0,0,0,0,0,0);
    add(0,0,1,0, 1,1,1,0,0,1,0,0,0);
    add(0,1,0,0, 1,1,1,0,0,1,0,0,0);
    // 2: down count through 0->7 wrap
    add(1,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,0,0, 0,1,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,1,0,0,0,0,0,0,0);
    add(0,7,1,0, 0,1,1,0,0,1,1,7,0);
    add(0,6,0,0, 0,1,1,0,0,1,1,7,0);
    // 3: direction change
    add(1,3,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,4,0,0, 1,1,0,0,0,0,0,0,0);
    add(0,5,0,0, 1,1,0,0,0,0,0,0,0);
    add(0,4,0,0, 0,1,0,0,0,1,2,4,0);
    add(0,3,0,0, 0,1,0,0,0,1,2,4,0);
    // 4: illegal step then reacquire
    add(1,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,0,0, 1,1,0,0,0,0,0,0,0);
    add(0,6,0,0, 1,0,0,1,0,1,3,6,0);
    add(0,7,0,0, 1,1,0,1,0,1,3,6,0);
    // 5a: five errors into a four-deep queue, then drain in order
    add(1,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,0,0, 0,0,0,1,0,1,3,3,0);
    add(0,6,0,0, 0,0,0,2,0,1,3,3,0);
    add(0,1,0,0, 0,0,0,3,0,1,3,3,0);
    add(0,4,0,0, 0,0,0,4,0,1,3,3,0);
    add(0,7,0,0, 0,0,0,5,0,1,3,3,1);
    add(0,6,0,1, 0,1,0,5,0,1,3,6,1);
    add(0,5,0,1, 0,1,0,5,0,1,3,1,1);
    add(0,4,0,1, 0,1,0,5,0,1,3,4,1);
    add(0,3,0,1, 0,1,0,5,0,0,0,0,1);
    // 5b: wrap without loop flag
    add(1,7,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,7,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,0, 1,1,1,0,1,1,0,0,0);
    add(0,1,0,0, 1,1,1,0,1,1,0,0,0);
    // 5c: loop high on a non-wrap step
    add(1,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,2,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,1,0, 1,1,0,0,1,0,0,0,0);
    // 6: reset with three events queued, then SYNC ignores the first step
    add(1,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,0,0, 0,0,0,1,0,1,3,3,0);
    add(0,6,0,0, 0,0,0,2,0,1,3,3,0);
    add(0,1,0,0, 0,0,0,3,0,1,3,3,0);
    add(1,1,0,0, 0,0,0,0,0,0,0,0,0);
    add(1,3,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,6,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,7,0,0, 1,1,0,0,0,0,0,0,0);
    // 7: push and pop together while full -> no overflow
    add(1,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,3,0,0, 0,0,0,1,0,1,3,3,0);
    add(0,6,0,0, 0,0,0,2,0,1,3,3,0);
    add(0,1,0,0, 0,0,0,3,0,1,3,3,0);
    add(0,4,0,0, 0,0,0,4,0,1,3,3,0);
    add(0,7,0,1, 0,0,0,5,0,1,3,6,0);
    add(0,2,0,1, 0,0,0,6,0,1,3,1,0);

    rst = 1'b1; count = '0; loop = 1'b0; evif.ev_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].cnt, vecs[i].lp, vecs[i].rdy);
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
    end

    // Drain the queue left by vector group 7 with legal up steps that add no events
    heads[0] = 3'd4; heads[1] = 3'd7; heads[2] = 3'd2; heads[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'(3 + i), 1'b0, 1'b1);
      check($sformatf("drain_valid%0d", i), 32'(evif.ev_valid), (i < 3) ? 32'd1 : 32'd0);
      check($sformatf("drain_count%0d", i), 32'(evif.ev_count), 32'(heads[i]));
    end
    check("drain_err_cnt", 32'(err_cnt), 32'd6);
    check("drain_overflow", 32'(ev_overflow), 32'd0);
    check("drain_dir", 32'({dir, dir_valid}), 32'd3);

    // err_cnt saturation over 300 illegal steps
    step(1'b1, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    c = 0;
    for (int i = 0; i < 300; i++) begin
      c = (c + 3) % 8;
      step(1'b0, 3'(c), 1'b0, 1'b1);
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    check("sat_no_overflow", 32'(ev_overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
